// File: rtl/layer_pkg.sv
// Shared fixed-point helpers for the layer blocks.
// Holds the word-width derivation, the squaring limit, the FSM state type and the saturating add/subtract.
package layer_pkg;

    localparam int unsigned DEF_INT_W  = 8;
    localparam int unsigned DEF_FRAC_W = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SUB    = 2'd1,
        SQ     = 2'd2,
        LAUNCH = 2'd3
    } state_t;

    function automatic int unsigned num_w(input int unsigned int_w, input int unsigned frac_w);
        return int_w + frac_w;
    endfunction

    localparam int unsigned DEF_NUM_W = num_w(DEF_INT_W, DEF_FRAC_W);

    // Largest raw magnitude whose fixed-point square still fits the positive range.
    function automatic int unsigned sq_limit(input int unsigned nw, input int unsigned frac_w);
        logic [63:0] n;
        logic [63:0] r;
        logic [63:0] t;
        n = ((64'd1 << (nw - 1)) - 64'd1) << frac_w;
        r = 64'd0;
        for (int b = 31; b >= 0; b--) begin
            t = r | (64'd1 << b);
            if (t * t <= n) r = t;
        end
        return 32'(r);
    endfunction

    function automatic logic signed [31:0] sat_clip(input logic signed [33:0] v, input int unsigned w);
        logic signed [33:0] mx;
        logic signed [33:0] mn;
        mx = (34'sd1 <<< (w - 1)) - 34'sd1;
        mn = -(34'sd1 <<< (w - 1));
        if (v > mx) return 32'(mx);
        if (v < mn) return 32'(mn);
        return 32'(v);
    endfunction

    function automatic logic signed [31:0] sat_add(input logic signed [31:0] a,
                                                   input logic signed [31:0] b,
                                                   input int unsigned w);
        return sat_clip(34'(a) + 34'(b), w);
    endfunction

    function automatic logic signed [31:0] sat_sub(input logic signed [31:0] a,
                                                   input logic signed [31:0] b,
                                                   input int unsigned w);
        return sat_clip(34'(a) - 34'(b), w);
    endfunction

endpackage

// File: rtl/loss_grad_if.sv
// Bus between loss_grad, its controller, the backward layer and the shared multiplier.
interface loss_grad_if #(
    parameter int unsigned OUTPUTS = 2,
    parameter int unsigned NUM_W   = 16
);
    logic                           start;
    logic                           ready_out;
    logic [OUTPUTS-1:0][NUM_W-1:0]  outputs_f;
    logic [OUTPUTS-1:0][NUM_W-1:0]  targets;
    logic [OUTPUTS-1:0][NUM_W-1:0]  diff;
    logic [NUM_W-1:0]               loss;
    logic                           start_b;
    logic                           ready_in;
    logic                           mult_en;
    logic [NUM_W-1:0]               mult_v1;
    logic [NUM_W-1:0]               mult_v2;
    logic [NUM_W-1:0]               mult_res;

    modport slave (
        input  start, outputs_f, targets, ready_in, mult_res,
        output ready_out, diff, loss, start_b, mult_en, mult_v1, mult_v2
    );

    modport master (
        output start, outputs_f, targets, ready_in, mult_res,
        input  ready_out, diff, loss, start_b, mult_en, mult_v1, mult_v2
    );
endinterface

// File: rtl/loss_grad_sq_acc.sv
// One squared-error term folded into the running loss with saturation.
// Magnitudes above the limit take the positive maximum instead of the multiplier result.
module sq_acc
    import layer_pkg::*;
#(
    parameter int unsigned NUM_W  = DEF_NUM_W,
    parameter int unsigned SQ_LIM = 2896
) (
    input  logic [NUM_W-1:0] i_diff,
    input  logic [NUM_W-1:0] i_mult_res,
    input  logic [NUM_W-1:0] i_loss,
    output logic [NUM_W-1:0] o_loss_c
);
    logic [NUM_W:0]   w_ext;
    logic [NUM_W:0]   w_mag;
    logic [NUM_W-1:0] w_term;

    // One extra bit so the most negative value has a representable magnitude.
    assign w_ext  = {i_diff[NUM_W-1], i_diff};
    assign w_mag  = i_diff[NUM_W-1] ? ((NUM_W+1)'(0) - w_ext) : w_ext;
    assign w_term = (w_mag > (NUM_W+1)'(SQ_LIM)) ? {1'b0, {(NUM_W-1){1'b1}}} : i_mult_res;

    assign o_loss_c = NUM_W'(sat_add(32'($signed(i_loss)), 32'($signed(w_term)), NUM_W));
endmodule

// File: rtl/loss_grad.sv
// Loss stage: saturating error vector, serial sum of squares through a shared multiplier,
// then a handshaked launch of the backward pass.
module loss_grad
    import layer_pkg::*;
#(
    parameter int unsigned OUTPUTS = 2,
    parameter int unsigned INT_W   = DEF_INT_W,
    parameter int unsigned FRAC_W  = DEF_FRAC_W
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         enable,
    loss_grad_if.slave   bus
);
    localparam int unsigned NUM_W  = num_w(INT_W, FRAC_W);
    localparam int unsigned SQ_LIM = sq_limit(NUM_W, FRAC_W);
    localparam int unsigned KW     = (OUTPUTS > 1) ? $clog2(OUTPUTS) : 1;

    state_t                        r_state;
    state_t                        w_state_nxt;
    logic [KW-1:0]                 r_k;
    logic [OUTPUTS-1:0][NUM_W-1:0] r_out_f;
    logic [OUTPUTS-1:0][NUM_W-1:0] r_tgt;
    logic [OUTPUTS-1:0][NUM_W-1:0] r_diff;
    logic [NUM_W-1:0]              r_loss;
    logic [NUM_W-1:0]              w_diff_k;
    logic [NUM_W-1:0]              w_loss_nxt;
    logic                          w_last;

    assign w_diff_k = r_diff[r_k];
    assign w_last   = (r_k == KW'(OUTPUTS - 1));

    sq_acc #(
        .NUM_W  (NUM_W),
        .SQ_LIM (SQ_LIM)
    ) u_sq_acc (
        .i_diff     (w_diff_k),
        .i_mult_res (bus.mult_res),
        .i_loss     (r_loss),
        .o_loss_c   (w_loss_nxt)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else if (enable) begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (bus.start)    w_state_nxt = SUB;
            SUB:                       w_state_nxt = SQ;
            SQ:      if (w_last)       w_state_nxt = LAUNCH;
            LAUNCH:  if (bus.ready_in) w_state_nxt = IDLE;
            default:                   w_state_nxt = IDLE;
        endcase
    end

    // Enable gates the multiplier request and the launch pulse in the same cycle.
    always_comb begin
        bus.ready_out = (r_state == IDLE);
        bus.start_b   = 1'b0;
        bus.mult_en   = 1'b0;
        bus.mult_v1   = '0;
        bus.mult_v2   = '0;
        if (enable) begin
            if (r_state == SQ) begin
                bus.mult_en = 1'b1;
                bus.mult_v1 = w_diff_k;
                bus.mult_v2 = w_diff_k;
            end
            if (r_state == LAUNCH) begin
                bus.start_b = bus.ready_in;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_k     <= '0;
            r_out_f <= '0;
            r_tgt   <= '0;
            r_diff  <= '0;
            r_loss  <= '0;
        end else if (enable) begin
            case (r_state)
                IDLE: begin
                    if (bus.start) begin
                        r_out_f <= bus.outputs_f;
                        r_tgt   <= bus.targets;
                        r_loss  <= '0;
                    end
                end
                SUB: begin
                    for (int i = 0; i < OUTPUTS; i++) begin
                        r_diff[i] <= NUM_W'(sat_sub(32'($signed(r_out_f[i])),
                                                    32'($signed(r_tgt[i])), NUM_W));
                    end
                    r_k <= '0;
                end
                SQ: begin
                    r_loss <= w_loss_nxt;
                    r_k    <= w_last ? '0 : r_k + KW'(1);
                end
                default: ;
            endcase
        end
    end

    assign bus.diff = r_diff;
    assign bus.loss = r_loss;
endmodule

// File: doc/loss_grad.md
LOSS_GRAD -- requirements
Module: loss_grad

Interface
REQ-001 SHALL have parameter OUTPUTS, default 2: element count of the upstream layer's forward result vector.
REQ-002 SHALL have parameter INT_W, default 8: integer bits of the signed fixed-point format.
REQ-003 SHALL have parameter FRAC_W, default 8: fraction bits; NUM_W = INT_W + FRAC_W.
REQ-004 SHALL have port clk  in  1  sole clock, rising edge.
REQ-005 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-006 SHALL have port enable  in  1  global advance; low freezes all state.
REQ-007 SHALL have ports start (in, 1), the capture request, and ready_out (out, 1), high when idle.
REQ-008 SHALL have port outputs_f  in  NUM_W x OUTPUTS  signed layer forward results.
REQ-009 SHALL have port targets  in  NUM_W x OUTPUTS  signed expected values.
REQ-010 SHALL have port diff  out  NUM_W x OUTPUTS  signed gradient, driving the layer's inputs_b.
REQ-011 SHALL have port loss  out  NUM_W  signed sum of squared errors, never negative.
REQ-012 SHALL have ports start_b (out, 1), the backward-launch pulse, and ready_in (in, 1), high when the layer accepts start_b.
REQ-013 SHALL have ports mult_en (out, 1), mult_v1 (out, NUM_W) and mult_v2 (out, NUM_W) to the shared combinational multiplier, plus mult_res (in, NUM_W), its result truncated by FRAC_W.

Function
REQ-014 SHALL implement states IDLE, SUB, SQ, LAUNCH; ready_out = (state == IDLE).
REQ-015 In IDLE with enable && start, SHALL register outputs_f and targets, clear loss to 0 and enter SUB; start outside IDLE SHALL be ignored.
REQ-016 In SUB, SHALL compute diff[k] = sat(outputs_f[k] - targets[k]) for all k in one cycle, clamp to [0x8000..0x7FFF] for NUM_W=16, then enter SQ with index k = 0.
REQ-017 In SQ, SHALL process one element per cycle: mult_en = 1 and mult_v1 = mult_v2 = diff[k].
REQ-018 In SQ, SHALL form term = 0x7FFF when |diff[k]| > SQ_LIMIT, else mult_res.
REQ-019 In SQ, SHALL set loss <= sat(loss + term), then k++; after k = OUTPUTS-1 it SHALL enter LAUNCH.
REQ-020 SQ_LIMIT SHALL be floor(sqrt((2^(NUM_W-1)-1) * 2^FRAC_W)) in raw units (0x0B50 for 8.8); |0x8000| SHALL be treated as exceeding SQ_LIMIT.
REQ-021 In LAUNCH, SHALL assert start_b for exactly the one cycle in which ready_in is high, then enter IDLE; while ready_in is low, SHALL hold with start_b = 0.
REQ-022 Latency with ready_in = 1: start at cycle 0, start_b at cycle OUTPUTS+2, ready_out high at cycle OUTPUTS+3.
REQ-023 mult_en, mult_v1 and mult_v2 SHALL be 0 outside SQ.
REQ-024 diff and loss SHALL hold their values from the end of SQ until the next accepted start.
REQ-025 With enable low, SHALL hold state, k, diff and loss, and force start_b = 0 and mult_en = 0.
REQ-026 Each subtraction and accumulation SHALL saturate independently; no wrap-around at any step.

Reset
REQ-027 reset SHALL override enable and apply on the next clk edge from any state.
REQ-028 On reset: state = IDLE, ready_out = 1, start_b = 0, diff = all 0, loss = 0, k = 0, mult_en/v1/v2 = 0.
REQ-029 reset asserted mid-SQ or mid-LAUNCH SHALL abort with no start_b pulse emitted.

Structure
REQ-030 A shared package (layer_pkg) SHALL hold NUM_W derivation, SQ_LIMIT, the state enum, and sat_add/sat_sub functions reused by layer blocks.
REQ-031 One sub-module, sq_acc (one squared-error term plus saturating accumulator), is natural; the FSM stays in loss_grad.

Verification
REQ-032 Scenario 1: OUTPUTS=2, 8.8; outputs_f = {0x0180, 0xFF00}, targets = {0x0100, 0x0000}, ready_in = 1 -> diff = {0x0080, 0xFF00}, loss = 0x0140, start_b at cycle 4.
REQ-033 Scenario 2: outputs_f[0] = 0x7F00, targets[0] = 0x8100 -> diff[0] = 0x7FFF, loss = 0x7FFF, multiplier result unused.
REQ-034 Scenario 3: ready_in low for 5 cycles in LAUNCH -> start_b stays 0 and diff/loss are stable; start_b pulses once, on the first cycle ready_in is high.
REQ-035 Scenario 4: start re-pulsed during SQ -> ignored, loss unchanged; enable low for 3 cycles mid-SQ -> latency extends by exactly 3.
REQ-036 Scenario 5: reset during SQ -> next cycle ready_out = 1, diff = 0, loss = 0, no start_b.
REQ-037 Scenario 6: outputs_f equal to targets -> diff all 0, loss = 0x0000.
